// File: rtl/fp80_normalize_pkg.sv
// Shared types and constants for the FP80 post-arithmetic normalizer.
// FP80_DENORM_EN selects gradual underflow instead of flush-to-zero.
package fp80_normalize_pkg;

  localparam logic [14:0] EXP_INF  = 15'h7FFF;
  localparam logic [14:0] EXP_BIAS = 15'h3FFF;
  localparam int          GRS_W    = 3;

  typedef struct packed {
    logic         sign;
    logic [14:0]  exp;
    logic [130:0] sig;
  } fp80x_t;

  typedef struct packed {
    logic              sign;
    logic [14:0]       exp;
    logic [63+GRS_W:0] sig;
  } fp80n_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_SPEC
  } cls_e;

  typedef struct packed {
    logic         valid;
    cls_e         cls;
    logic         sign;
    logic [14:0]  exp;
    logic [16:0]  e;
    logic [129:0] sig;
    logic         unf;
  } stage_t;

  function automatic logic is_special(fp80x_t x);
    return x.exp == EXP_INF;
  endfunction

endpackage

// File: rtl/fp80_normalize_if.sv
// Handshake bundle between the FP80X producer, normalizer and rounder.
// Slave is the normalizer side; master is the surrounding logic.
interface fp80_normalize_if
  import fp80_normalize_pkg::*;
  ();

  fp80x_t i;
  logic   i_valid;
  logic   i_ready;
  fp80n_t o;
  logic   o_valid;
  logic   o_ready;
  logic   o_ovf;
  logic   o_unf;

  modport slave (
    input  i, i_valid, o_ready,
    output i_ready, o, o_valid, o_ovf, o_unf
  );

  modport master (
    output i, i_valid, o_ready,
    input  i_ready, o, o_valid, o_ovf, o_unf
  );

endinterface

// File: rtl/fp80_normalize_lzc130.sv
// Combinational leading-zero counter over a 130-bit significand.
// All-zero input reports 130.
module fp80_lzc130 (
  input  logic [129:0] x,
  output logic [7:0]   lz
);

  always_comb begin
    lz = 8'd130;
    for (int k = 0; k < 130; k++)
      if (x[k]) lz = 8'(129 - k);
  end

endmodule

// File: rtl/fp80_normalize.sv
// Three-stage FP80X -> FP80N normalizer: classify/carry, LZC shift, pack.
// Define FP80_DENORM_EN for gradual underflow; otherwise tiny results flush.
module fp80_normalize
  import fp80_normalize_pkg::*;
#(
  parameter int STAGES = 3
) (
  input logic               clk,
  input logic               rst_n,
  fp80_normalize_if.slave   bus
);

  logic        adv;
  stage_t      n1, s1, n2, s2;
  logic [16:0] e0;
  logic [7:0]  lz, sh;
  logic        flush;
  fp80n_t      o_n;
  logic        ovf_n, unf_n;

  assign adv         = !bus.o_valid | bus.o_ready;
  assign bus.i_ready = adv;

  always_comb begin
    e0 = (bus.i.exp == '0) ? 17'd1 : {2'b00, bus.i.exp};
    n1 = '0;
    n1.valid = bus.i_valid;
    n1.sign  = bus.i.sign;
    n1.exp   = bus.i.exp;
    n1.e     = e0;
    n1.sig   = bus.i.sig[129:0];
    n1.cls   = CLS_NORM;
    if (is_special(bus.i))
      n1.cls = CLS_SPEC;
    else if (bus.i.sig == '0)
      n1.cls = CLS_ZERO;
`ifndef FP80_DENORM_EN
    else if (bus.i.exp == '0) begin
      n1.cls = CLS_ZERO;
      n1.unf = 1'b1;
    end
`endif
    else if (bus.i.sig[130]) begin
      // keep the dropped bit as sticky in the new lsb
      n1.sig = {bus.i.sig[130:2], |bus.i.sig[1:0]};
      n1.e   = e0 + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s1 <= '0;
    else if (adv) s1 <= n1;
  end

  fp80_lzc130 u_lzc (
    .x  (s1.sig),
    .lz (lz)
  );

`ifdef FP80_DENORM_EN
  logic [16:0] em1;
  assign em1 = s1.e - 17'd1;
  assign sh  = (em1 < {9'd0, lz}) ? em1[7:0] : lz;
  assign flush = 1'b0;
`else
  assign sh    = lz;
  assign flush = ({9'd0, lz} >= s1.e);
`endif

  always_comb begin
    n2 = s1;
    if (s1.cls == CLS_NORM) begin
      if (flush) begin
        n2.cls = CLS_ZERO;
        n2.unf = 1'b1;
      end else begin
        n2.sig = s1.sig << sh;
        n2.e   = s1.e - {9'd0, sh};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s2 <= '0;
    else if (adv) s2 <= n2;
  end

  always_comb begin
    o_n      = '0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    o_n.sign = s2.sign;
    unique case (s2.cls)
      CLS_SPEC: begin
        o_n.exp = s2.exp;
        o_n.sig = {s2.sig[129:66], 2'b00, |s2.sig[65:0]};
      end
      CLS_ZERO: begin
        unf_n = s2.unf;
      end
      default: begin
        o_n.sig = {s2.sig[129:64], |s2.sig[63:0]};
        if (!s2.sig[129]) begin
          unf_n = 1'b1;
        end else if (s2.e >= {2'b00, EXP_INF}) begin
          o_n.exp = EXP_INF;
          o_n.sig = {1'b1, 66'd0};
          ovf_n   = 1'b1;
        end else begin
          o_n.exp = s2.e[14:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o       <= '0;
      bus.o_valid <= 1'b0;
      bus.o_ovf   <= 1'b0;
      bus.o_unf   <= 1'b0;
    end else if (adv) begin
      bus.o       <= o_n;
      bus.o_valid <= s2.valid;
      bus.o_ovf   <= ovf_n & s2.valid;
      bus.o_unf   <= unf_n & s2.valid;
    end
  end

  a_depth: assert property (
    @(posedge clk) disable iff (!rst_n)
    $countones({s1.valid, s2.valid, bus.o_valid}) <= STAGES
  );

endmodule
